// File: rtl/hc_pkg.sv
// Shared constants and FSM encoding for the HC keystream consumer.
package hc_pkg;
    localparam int HC_WORD_WIDTH = 32;
    localparam int HC_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } hc_state_e;
endpackage

// File: rtl/hc_stream_xor_if.sv
// Core keystream handshake plus din/dout valid/ready streams of hc_stream_xor.
interface hc_stream_xor_if;
    import hc_pkg::*;

    logic                     core_next;
    logic [HC_WORD_WIDTH-1:0] core_s;
    logic                     core_s_valid;
    logic [HC_WORD_WIDTH-1:0] din;
    logic                     din_valid;
    logic                     din_ready;
    logic [HC_WORD_WIDTH-1:0] dout;
    logic                     dout_valid;
    logic                     dout_ready;

    modport slave (
        output core_next, din_ready, dout, dout_valid,
        input  core_s, core_s_valid, din, din_valid, dout_ready
    );

    modport master (
        input  core_next, din_ready, dout, dout_valid,
        output core_s, core_s_valid, din, din_valid, dout_ready
    );
endinterface

// File: rtl/hc_ks_fifo.sv
// First-word-fall-through keystream FIFO with fill count and synchronous flush.
module hc_ks_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [W-1:0]           wdata_i,
    input  logic                   pop_i,
    output logic [W-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: the count gates every read of it.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = cnt_q;
endmodule

// File: rtl/hc_stream_xor.sv
// Prefetches HC keystream words into a FIFO and XORs them onto a valid/ready data stream.
module hc_stream_xor
    import hc_pkg::*;
#(
    parameter int FIFO_DEPTH = HC_FIFO_DEPTH,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        flush,
    hc_stream_xor_if.slave              bus,
    output logic [$clog2(FIFO_DEPTH):0] ks_level,
    output logic [CNT_WIDTH-1:0]        word_count
);
    localparam int          AW   = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    hc_state_e                state_q;
    logic                     core_next_q, sv_prev_q;
    logic                     dout_valid_q, dout_valid_d;
    logic [HC_WORD_WIDTH-1:0] dout_q, dout_d, ks_head;
    logic [CNT_WIDTH-1:0]     word_count_q, word_count_d;
    logic                     s_rise, push, pop, din_ready;

    // Only a fresh rising edge marks a new word; a level held from before is ignored.
    assign s_rise    = bus.core_s_valid & ~sv_prev_q;
    assign push      = (state_q == ST_WAIT) & s_rise & ~flush;
    assign din_ready = enable & (ks_level != '0) & (~dout_valid_q | bus.dout_ready) & ~flush;
    assign pop       = bus.din_valid & din_ready;

    hc_ks_fifo #(.DEPTH(FIFO_DEPTH), .W(HC_WORD_WIDTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (flush),
        .push_i  (push),
        .wdata_i (bus.core_s),
        .pop_i   (pop),
        .rdata_o (ks_head),
        .count_o (ks_level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            core_next_q <= 1'b0;
            sv_prev_q   <= 1'b0;
        end else begin
            sv_prev_q   <= bus.core_s_valid;
            core_next_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (!flush && enable && ks_level < FULL) begin
                    state_q     <= ST_REQ;
                    core_next_q <= 1'b1;
                end
                ST_REQ:  state_q <= flush ? ST_IDLE : ST_WAIT;
                // A word arriving in the flush cycle is already gone, so no drain is needed.
                ST_WAIT: begin
                    if (flush)       state_q <= s_rise ? ST_IDLE : ST_DRAIN;
                    else if (s_rise) state_q <= ST_IDLE;
                end
                ST_DRAIN: if (s_rise) state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        word_count_d = word_count_q;
        if (pop) begin
            dout_d       = bus.din ^ ks_head;
            dout_valid_d = 1'b1;
        end else if (bus.dout_ready) begin
            dout_valid_d = 1'b0;
        end
        if (flush)    word_count_d = '0;
        else if (pop) word_count_d = word_count_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            word_count_q <= '0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            word_count_q <= word_count_d;
        end
    end

    assign bus.core_next  = core_next_q;
    assign bus.din_ready  = din_ready;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign word_count     = word_count_q;
endmodule

// File: tb/tb_hc_stream_xor.sv
// Directed scoreboard bench for hc_stream_xor with an inline HC core responder.
module tb_hc_stream_xor;
    import hc_pkg::*;

    logic        clk = 1'b0;
    logic        reset, enable, flush;
    logic [2:0]  ks_level;
    logic [31:0] word_count;

    hc_stream_xor_if bus();

    hc_stream_xor #(.FIFO_DEPTH(4), .CNT_WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .flush      (flush),
        .bus        (bus),
        .ks_level   (ks_level),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0;
    logic [31:0] sb_q[$];
    logic [31:0] key_q[$];
    int          dly = 0, widx = 1, nexts = 0;
    bit          pend = 0, discard = 0, model_en = 1, hs_prev = 0, bp_chk = 0, found;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Core responder: word k is k*0x11111111, pulsed valid 3 cycles after core_next.
    task automatic core_model();
        if (pend) begin
            pend = 0;
            bus.core_s_valid = 1'b0;
            if (discard) discard = 0;
            else key_q.push_back(bus.core_s);
        end
        if (bus.core_next) begin
            nexts++;
            if (model_en) dly = 3;
        end else if (dly > 0) begin
            dly--;
            if (dly == 0) begin
                bus.core_s       = 32'(widx) * 32'h11111111;
                bus.core_s_valid = 1'b1;
                widx++;
                pend = 1;
            end
        end
    endtask

    // One clock: entered and left on a falling edge.
    task automatic step(input logic dv, input logic [31:0] d, input logic rdy, input logic fl);
        core_model();
        bus.din_valid  = dv;
        bus.din        = d;
        bus.dout_ready = rdy;
        flush          = fl;
        #1;
        if (hs_prev) chk("latency_valid", 32'(bus.dout_valid), 32'd1);
        if (bp_chk) begin
            chk("bp_din_ready", 32'(bus.din_ready), 32'd0);
            chk("bp_dout_held", bus.dout, sb_q[0]);
            chk("bp_level", 32'(ks_level), 32'(key_q.size()));
        end
        if (fl) chk("flush_din_ready", 32'(bus.din_ready), 32'd0);
        if (bus.dout_valid && bus.dout_ready) begin
            chk("out_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) chk("dout", bus.dout, sb_q.pop_front());
        end
        hs_prev = bus.din_valid && bus.din_ready;
        if (hs_prev) begin
            chk("key_available", 32'(key_q.size() != 0), 32'd1);
            if (key_q.size() != 0) sb_q.push_back(d ^ key_q.pop_front());
        end
        if (fl) key_q.delete();
        @(negedge clk);
    endtask

    task automatic wait_next();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
            if (bus.core_next) found = 1;
        end
        chk("core_next_seen", 32'(found), 32'd1);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; flush = 1'b0;
        bus.din = '0; bus.din_valid = 1'b0; bus.dout_ready = 1'b0;
        bus.core_s = '0; bus.core_s_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_core_next", 32'(bus.core_next), 32'd0);
        chk("rst_din_ready", 32'(bus.din_ready), 32'd0);
        chk("rst_dout", bus.dout, 32'd0);
        chk("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
        chk("rst_ks_level", 32'(ks_level), 32'd0);
        chk("rst_word_count", word_count, 32'd0);
        reset = 1'b0;
        enable = 1'b1;

        // Prefetch fills to depth and stops requesting.
        repeat (60) step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("prefetch_pulses", 32'(nexts), 32'd4);
        chk("prefetch_level", 32'(ks_level), 32'd4);

        // Encrypt four words back to back.
        repeat (4) step(1'b1, 32'hAAAAAAAA, 1'b1, 1'b0);
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("enc_word_count", word_count, 32'd4);
        chk("enc_all_out", 32'(sb_q.size()), 32'd0);

        repeat (40) step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("refill_level", 32'(ks_level), 32'd4);

        // Backpressure then release.
        step(1'b1, 32'h0F0F0F0F, 1'b1, 1'b0);
        bp_chk = 1;
        repeat (5) step(1'b1, 32'h13579BDF, 1'b0, 1'b0);
        bp_chk = 0;
        for (int i = 0; i < 3; i++) step(1'b1, 32'h2468ACE0 + 32'(i), 1'b1, 1'b0);
        repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("bp_no_loss", 32'(sb_q.size()), 32'd0);

        // Stale valid: level held high across a request must not be captured.
        repeat (40) step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("stale_full", 32'(ks_level), 32'd4);
        model_en = 0;
        bus.core_s = 32'hDEADBEEF;
        bus.core_s_valid = 1'b1;
        step(1'b1, 32'h0, 1'b1, 1'b0);
        wait_next();
        repeat (6) step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("stale_no_capture", 32'(ks_level), 32'd3);
        bus.core_s_valid = 1'b0;
        step(1'b0, 32'h0, 1'b1, 1'b0);
        bus.core_s = 32'hCAFEF00D;
        bus.core_s_valid = 1'b1;
        repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("stale_recapture", 32'(ks_level), 32'd4);
        key_q.push_back(32'hCAFEF00D);
        bus.core_s_valid = 1'b0;
        model_en = 1;

        // Flush one cycle after core_next: in-flight word is drained away.
        step(1'b1, 32'h12345678, 1'b1, 1'b0);
        wait_next();
        step(1'b0, 32'h0, 1'b1, 1'b0);
        discard = 1;
        step(1'b1, 32'h55AA55AA, 1'b1, 1'b1);
        chk("flush_level", 32'(ks_level), 32'd0);
        chk("flush_word_count", word_count, 32'd0);
        repeat (40) step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("flush_refill", 32'(ks_level), 32'd4);
        chk("flush_discarded", 32'(discard), 32'd0);
        step(1'b1, 32'h0BADF00D, 1'b1, 1'b0);
        repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("post_flush_count", word_count, 32'd1);
        chk("post_flush_out", 32'(sb_q.size()), 32'd0);

        // Asynchronous reset mid-burst, between clock edges.
        step(1'b1, 32'hFFFF0000, 1'b1, 1'b0);
        step(1'b1, 32'h0000FFFF, 1'b1, 1'b0);
        chk("pre_rst_valid", 32'(bus.dout_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_dout_valid", 32'(bus.dout_valid), 32'd0);
        chk("arst_core_next", 32'(bus.core_next), 32'd0);
        chk("arst_ks_level", 32'(ks_level), 32'd0);
        chk("arst_word_count", word_count, 32'd0);
        chk("arst_dout", bus.dout, 32'd0);
        sb_q.delete();
        key_q.delete();
        pend = 0; dly = 0; discard = 0; hs_prev = 0;
        bus.core_s_valid = 1'b0;
        bus.din_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("post_rst_valid", 32'(bus.dout_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1);
    end
endmodule
